// File: rtl/link_status_regs_pkg.sv
// rtl/link_status_regs_pkg.sv - shared definitions for the per-channel link status register block
// Holds register word offsets, STATUS/CONTROL bit positions, the read FSM
// state encoding and the default unmapped-read value.
package link_status_regs_pkg;

  // Register word offsets
  localparam int OFF_STATUS    = 0;
  localparam int OFF_FRAME_ERR = 1;
  localparam int OFF_HARD_ERR  = 2;
  localparam int OFF_SOFT_ERR  = 3;
  localparam int OFF_CHAN_DOWN = 4;
  localparam int OFF_CONTROL   = 5;
  localparam int OFF_SCRATCH   = 6;

  // STATUS bit positions
  localparam int ST_CHANNEL_UP     = 0;
  localparam int ST_LANE_UP        = 1;
  localparam int ST_PLL_NOT_LOCKED = 2;
  localparam int ST_TX_RESETDONE   = 3;
  localparam int ST_RX_RESETDONE   = 4;
  localparam int ST_LINK_RESET     = 5;

  // CONTROL bit positions
  localparam int CTRL_CLR_BIT = 0;
  localparam int CTRL_RST_BIT = 1;
  localparam int CTRL_LB_LSB  = 2;
  localparam int CTRL_LB_MSB  = 4;

  localparam logic [31:0] UNMAPPED_VAL_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_LATCH = 2'd1,
    RD_ACK   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/link_status_regs_edge_sat_counter.sv
// rtl/link_status_regs_edge_sat_counter.sv - rising-edge event counter that saturates at all-ones
// Ports: io_clk, io_clk_resetN (sync, active-low), clr (clear this cycle),
//        in (event level), count (WIDTH-bit saturating count).
module edge_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             io_clk,
  input  logic             io_clk_resetN,
  input  logic             clr,
  input  logic             in,
  output logic [WIDTH-1:0] count
);

  logic             in_q;
  logic [WIDTH-1:0] base;

  // Clear takes priority, then a same-cycle edge counts on top of zero.
  always_comb begin
    base = clr ? '0 : count;
  end

  always_ff @(posedge io_clk) begin
    // in_q follows the input even in reset so a level held across reset
    // release is not mistaken for a fresh edge.
    in_q <= in;
    if (!io_clk_resetN) begin
      count <= '0;
    end else if (in && !in_q && (base != '1)) begin
      count <= base + 1'b1;
    end else begin
      count <= base;
    end
  end

endmodule

// File: rtl/link_status_regs.sv
// rtl/link_status_regs.sv - IPbus-side status/counter/control register responder for one Aurora channel
// Ports: io_clk / io_clk_resetN (sync, active-low); io_sel, io_sync, io_addr,
//        io_rd_en, io_wr_en, io_wr_data in; io_rd_data, io_rd_ack out;
//        Aurora error and status levels in; link_reset_req pulse and
//        loopback select out.
module link_status_regs
  import link_status_regs_pkg::*;
#(
  parameter int          CNT_WIDTH    = 16,
  parameter int          ADDR_BITS    = 4,
  parameter logic [31:0] UNMAPPED_VAL = UNMAPPED_VAL_DEFAULT,
  parameter logic [31:0] SCRATCH_INIT = 32'h0
) (
  input  logic        io_clk,
  input  logic        io_clk_resetN,
  input  logic        io_sel,
  input  logic        io_sync,
  input  logic [19:0] io_addr,
  input  logic        io_rd_en,
  input  logic        io_wr_en,
  input  logic [31:0] io_wr_data,
  output logic [31:0] io_rd_data,
  output logic        io_rd_ack,
  input  logic        frame_err,
  input  logic        hard_err,
  input  logic        soft_err,
  input  logic        channel_up,
  input  logic        lane_up,
  input  logic        pll_not_locked,
  input  logic        tx_resetdone,
  input  logic        rx_resetdone,
  input  logic        link_reset,
  output logic        link_reset_req,
  output logic [2:0]  loopback
);

  logic                 mapped;
  logic [ADDR_BITS-1:0] offset;
  logic                 wr_ctrl;
  logic                 wr_scratch;
  logic                 clr_cnt;
  logic                 chan_down;
  logic [CNT_WIDTH-1:0] frame_cnt, hard_cnt, soft_cnt, down_cnt;
  logic [31:0]          scratch;
  logic [31:0]          rd_mux;
  rd_state_t            state;
  logic                 io_sync_q;

  assign mapped     = (io_addr[19:ADDR_BITS] == '0);
  assign offset     = io_addr[ADDR_BITS-1:0];
  assign wr_ctrl    = io_sel && io_wr_en && mapped && (offset == ADDR_BITS'(OFF_CONTROL));
  assign wr_scratch = io_sel && io_wr_en && mapped && (offset == ADDR_BITS'(OFF_SCRATCH));
  // Clear is applied on the write edge itself so counters read zero the
  // cycle after the write, and an edge on that same edge still counts.
  assign clr_cnt    = wr_ctrl && io_wr_data[CTRL_CLR_BIT];
  // Counting rising edges of ~channel_up gives channel-down transitions.
  assign chan_down  = ~channel_up;

  edge_sat_counter #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
    .io_clk(io_clk), .io_clk_resetN(io_clk_resetN), .clr(clr_cnt), .in(frame_err), .count(frame_cnt));
  edge_sat_counter #(.WIDTH(CNT_WIDTH)) u_hard_cnt (
    .io_clk(io_clk), .io_clk_resetN(io_clk_resetN), .clr(clr_cnt), .in(hard_err), .count(hard_cnt));
  edge_sat_counter #(.WIDTH(CNT_WIDTH)) u_soft_cnt (
    .io_clk(io_clk), .io_clk_resetN(io_clk_resetN), .clr(clr_cnt), .in(soft_err), .count(soft_cnt));
  edge_sat_counter #(.WIDTH(CNT_WIDTH)) u_down_cnt (
    .io_clk(io_clk), .io_clk_resetN(io_clk_resetN), .clr(clr_cnt), .in(chan_down), .count(down_cnt));

  always_comb begin
    rd_mux = UNMAPPED_VAL;
    if (mapped) begin
      case (offset)
        ADDR_BITS'(OFF_STATUS): begin
          rd_mux                    = '0;
          rd_mux[ST_CHANNEL_UP]     = channel_up;
          rd_mux[ST_LANE_UP]        = lane_up;
          rd_mux[ST_PLL_NOT_LOCKED] = pll_not_locked;
          rd_mux[ST_TX_RESETDONE]   = tx_resetdone;
          rd_mux[ST_RX_RESETDONE]   = rx_resetdone;
          rd_mux[ST_LINK_RESET]     = link_reset;
        end
        ADDR_BITS'(OFF_FRAME_ERR): rd_mux = 32'(frame_cnt);
        ADDR_BITS'(OFF_HARD_ERR):  rd_mux = 32'(hard_cnt);
        ADDR_BITS'(OFF_SOFT_ERR):  rd_mux = 32'(soft_cnt);
        ADDR_BITS'(OFF_CHAN_DOWN): rd_mux = 32'(down_cnt);
        ADDR_BITS'(OFF_CONTROL): begin
          // Self-clearing bits always read back as zero.
          rd_mux                            = '0;
          rd_mux[CTRL_LB_MSB:CTRL_LB_LSB]   = loopback;
        end
        ADDR_BITS'(OFF_SCRATCH):   rd_mux = scratch;
        default:                   rd_mux = UNMAPPED_VAL;
      endcase
    end
  end

  // Write side runs independently of the read FSM.
  always_ff @(posedge io_clk) begin
    if (!io_clk_resetN) begin
      link_reset_req <= 1'b0;
      loopback       <= 3'b000;
      scratch        <= SCRATCH_INIT;
    end else begin
      link_reset_req <= wr_ctrl && io_wr_data[CTRL_RST_BIT];
      if (wr_ctrl) begin
        loopback <= io_wr_data[CTRL_LB_MSB:CTRL_LB_LSB];
      end
      if (wr_scratch) begin
        scratch <= io_wr_data;
      end
    end
  end

  // Read FSM: one snapshot and one ack per io_sync rising edge.
  always_ff @(posedge io_clk) begin
    if (!io_clk_resetN) begin
      state      <= RD_IDLE;
      io_rd_ack  <= 1'b0;
      io_rd_data <= 32'h0;
      io_sync_q  <= 1'b0;
    end else begin
      io_sync_q <= io_sync;
      case (state)
        RD_IDLE: begin
          if (io_sync && !io_sync_q && io_rd_en && io_sel) begin
            state <= RD_LATCH;
          end
        end
        RD_LATCH: begin
          if (!io_sync) begin
            state <= RD_IDLE;
          end else begin
            io_rd_data <= rd_mux;
            io_rd_ack  <= 1'b1;
            state      <= RD_ACK;
          end
        end
        RD_ACK: begin
          if (!io_sync) begin
            io_rd_ack <= 1'b0;
            state     <= RD_IDLE;
          end
        end
        default: begin
          io_rd_ack <= 1'b0;
          state     <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_status_regs.sv
// tb/tb_link_status_regs.sv - self-checking bench for link_status_regs against a behavioural model
module tb_link_status_regs;

  logic        io_clk = 1'b0;
  logic        io_clk_resetN = 1'b0;
  logic        io_sel = 1'b0, io_sync = 1'b0, io_rd_en = 1'b0, io_wr_en = 1'b0;
  logic [19:0] io_addr = 20'h0;
  logic [31:0] io_wr_data = 32'h0;
  logic        frame_err = 0, hard_err = 0, soft_err = 0;
  logic        channel_up = 0, lane_up = 0, pll_not_locked = 0;
  logic        tx_resetdone = 0, rx_resetdone = 0, link_reset = 0;

  logic [31:0] io_rd_data, rd_data4;
  logic        io_rd_ack, rd_ack4;
  logic        link_reset_req, lrr4;
  logic [2:0]  loopback, lb4;

  int errors = 0;
  int checks = 0;

  always #5 io_clk = ~io_clk;

  link_status_regs dut (
    .io_clk(io_clk), .io_clk_resetN(io_clk_resetN), .io_sel(io_sel), .io_sync(io_sync),
    .io_addr(io_addr), .io_rd_en(io_rd_en), .io_wr_en(io_wr_en), .io_wr_data(io_wr_data),
    .io_rd_data(io_rd_data), .io_rd_ack(io_rd_ack),
    .frame_err(frame_err), .hard_err(hard_err), .soft_err(soft_err),
    .channel_up(channel_up), .lane_up(lane_up), .pll_not_locked(pll_not_locked),
    .tx_resetdone(tx_resetdone), .rx_resetdone(rx_resetdone), .link_reset(link_reset),
    .link_reset_req(link_reset_req), .loopback(loopback));

  link_status_regs #(.CNT_WIDTH(4)) dut4 (
    .io_clk(io_clk), .io_clk_resetN(io_clk_resetN), .io_sel(io_sel), .io_sync(io_sync),
    .io_addr(io_addr), .io_rd_en(io_rd_en), .io_wr_en(io_wr_en), .io_wr_data(io_wr_data),
    .io_rd_data(rd_data4), .io_rd_ack(rd_ack4),
    .frame_err(frame_err), .hard_err(hard_err), .soft_err(soft_err),
    .channel_up(channel_up), .lane_up(lane_up), .pll_not_locked(pll_not_locked),
    .tx_resetdone(tx_resetdone), .rx_resetdone(rx_resetdone), .link_reset(link_reset),
    .link_reset_req(lrr4), .loopback(lb4));

  // Reference model: unbounded event tallies since last clear; saturation
  // is applied only when a value is read.
  int          m_cnt [4];
  logic [3:0]  m_prev;
  logic [2:0]  exp_lb = 3'b000;
  logic [31:0] exp_scratch = 32'h0;
  wire  [3:0]  m_in  = {~channel_up, soft_err, hard_err, frame_err};
  wire         m_clr = io_sel && io_wr_en && (io_addr == 20'd5) && io_wr_data[0];

  always @(posedge io_clk) begin
    m_prev <= m_in;
    for (int k = 0; k < 4; k++) begin
      if (!io_clk_resetN)                 m_cnt[k] <= 0;
      else if (m_in[k] && !m_prev[k])     m_cnt[k] <= (m_clr ? 0 : m_cnt[k]) + 1;
      else if (m_clr)                     m_cnt[k] <= 0;
    end
  end

  function automatic logic [31:0] sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? 32'(mx) : 32'(c);
  endfunction

  function automatic logic [31:0] exp_reg(input logic [19:0] a, input int w);
    if (a[19:4] != 16'h0) return 32'hDEADBEEF;
    case (a[3:0])
      4'd0: return {26'h0, link_reset, rx_resetdone, tx_resetdone, pll_not_locked, lane_up, channel_up};
      4'd1: return sat(m_cnt[0], w);
      4'd2: return sat(m_cnt[1], w);
      4'd3: return sat(m_cnt[2], w);
      4'd4: return sat(m_cnt[3], w);
      4'd5: return {27'h0, exp_lb, 2'b00};
      4'd6: return exp_scratch;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  logic [31:0] rd, rd4, e, e4;
  int          lat, acks;
  bit          hold_ok, drop_ok, prev_ack;

  task automatic do_write(input logic [19:0] a, input logic [31:0] d, input bit with_hard);
    @(negedge io_clk);
    io_sel = 1; io_wr_en = 1; io_addr = a; io_wr_data = d;
    if (with_hard) hard_err = 1;
    @(posedge io_clk); #1;
    io_wr_en = 0; io_sel = 0;
    if (a == 20'd5) exp_lb = d[4:2];
    if (a == 20'd6) exp_scratch = d;
  endtask

  task automatic do_read(input logic [19:0] a, input bit poke);
    @(negedge io_clk);
    io_sel = 1; io_sync = 1; io_rd_en = 1; io_addr = a;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge io_clk); #1;
      if (io_rd_ack) begin lat = i; break; end
    end
    rd = io_rd_data; rd4 = rd_data4;
    hold_ok = (lat > 0) && rd_ack4;
    if (poke) begin
      @(negedge io_clk); frame_err = 1;
      @(negedge io_clk); frame_err = 0;
    end
    repeat (3) begin
      @(posedge io_clk); #1;
      if (!io_rd_ack || !rd_ack4 || io_rd_data !== rd || rd_data4 !== rd4) hold_ok = 0;
    end
    @(negedge io_clk);
    io_sync = 0; io_rd_en = 0; io_sel = 0;
    @(posedge io_clk); #1;
    drop_ok = !io_rd_ack && !rd_ack4;
  endtask

  task automatic pulse(input int which, input int hi);
    @(negedge io_clk);
    case (which) 0: frame_err = 1; 1: hard_err = 1; default: soft_err = 1; endcase
    repeat (hi) @(negedge io_clk);
    case (which) 0: frame_err = 0; 1: hard_err = 0; default: soft_err = 0; endcase
  endtask

  task automatic test_reset;
    repeat (3) @(negedge io_clk);
    io_clk_resetN = 1;
    @(posedge io_clk); #1;
    checks++; if (io_rd_data !== 32'h0 || io_rd_ack !== 1'b0) begin errors++;
      $display("FAIL reset_rd got data=%h ack=%b want 0/0", io_rd_data, io_rd_ack); end
    checks++; if (link_reset_req !== 1'b0 || loopback !== 3'b000) begin errors++;
      $display("FAIL reset_ctrl got req=%b lb=%b want 0/000", link_reset_req, loopback); end
  endtask

  task automatic test_status;
    @(negedge io_clk); channel_up = 1; lane_up = 1;
    e = exp_reg(20'd0, 16);
    do_read(20'd0, 0);
    checks++; if (lat != 2) begin errors++; $display("FAIL status_latency got %0d want 2", lat); end
    checks++; if (rd !== e) begin errors++; $display("FAIL status_data got %h want %h", rd, e); end
    checks++; if (!hold_ok) begin errors++; $display("FAIL status_hold got unstable want stable ack"); end
    checks++; if (!drop_ok) begin errors++; $display("FAIL status_drop got ack=%b want 0", io_rd_ack); end
    for (int i = 0; i < 6; i++) begin
      @(negedge io_clk);
      {link_reset, rx_resetdone, tx_resetdone, pll_not_locked, lane_up, channel_up} = 6'($urandom);
      e = exp_reg(20'd0, 16);
      do_read(20'd0, 0);
      checks++; if (rd !== e || lat != 2) begin errors++;
        $display("FAIL status_rand got %h lat %0d want %h lat 2", rd, lat, e); end
    end
  endtask

  task automatic test_counters;
    @(negedge io_clk); channel_up = 1;
    do_write(20'd5, 32'h1, 0);
    pulse(0, 3);
    repeat (5) pulse(0, 1);
    e = exp_reg(20'd1, 16); e4 = exp_reg(20'd1, 4);
    do_read(20'd1, 0);
    checks++; if (rd !== e || rd4 !== e4) begin errors++;
      $display("FAIL frame_cnt got %h/%h want %h/%h", rd, rd4, e, e4); end
    repeat (20) pulse(0, 1);
    e = exp_reg(20'd1, 16); e4 = exp_reg(20'd1, 4);
    do_read(20'd1, 1);
    checks++; if (rd !== e || rd4 !== e4) begin errors++;
      $display("FAIL frame_sat got %h/%h want %h/%h", rd, rd4, e, e4); end
    checks++; if (!hold_ok) begin errors++; $display("FAIL snapshot got data changed want held"); end
    e = exp_reg(20'd1, 16); e4 = exp_reg(20'd1, 4);
    do_read(20'd1, 0);
    checks++; if (rd !== e || rd4 !== e4) begin errors++;
      $display("FAIL frame_after_poke got %h/%h want %h/%h", rd, rd4, e, e4); end
    for (int i = 0; i < 40; i++) begin
      @(negedge io_clk); soft_err = 1'($urandom); channel_up = 1'($urandom);
    end
    @(negedge io_clk); soft_err = 0; channel_up = 1;
    for (int r = 3; r <= 4; r++) begin
      e = exp_reg(20'(r), 16); e4 = exp_reg(20'(r), 4);
      do_read(20'(r), 0);
      checks++; if (rd !== e || rd4 !== e4) begin errors++;
        $display("FAIL rand_cnt_%0d got %h/%h want %h/%h", r, rd, rd4, e, e4); end
    end
  endtask

  task automatic test_clear_edge;
    do_write(20'd5, 32'h1, 0);
    repeat (7) pulse(1, 1);
    e = exp_reg(20'd2, 16);
    do_read(20'd2, 0);
    checks++; if (rd !== e) begin errors++; $display("FAIL hard_cnt7 got %h want %h", rd, e); end
    do_write(20'd5, 32'h1, 1);
    repeat (2) @(negedge io_clk);
    hard_err = 0;
    e = exp_reg(20'd2, 16); e4 = exp_reg(20'd2, 4);
    do_read(20'd2, 0);
    checks++; if (rd !== e || rd4 !== e4) begin errors++;
      $display("FAIL clear_edge got %h/%h want %h/%h", rd, rd4, e, e4); end
    e = exp_reg(20'd1, 16);
    do_read(20'd1, 0);
    checks++; if (rd !== e) begin errors++; $display("FAIL clear_frame got %h want %h", rd, e); end
  endtask

  task automatic test_control;
    do_write(20'd5, 32'h16, 0);
    checks++; if (link_reset_req !== 1'b1 || lrr4 !== 1'b1) begin errors++;
      $display("FAIL lrr_pulse got %b want 1", link_reset_req); end
    checks++; if (loopback !== exp_lb || lb4 !== exp_lb) begin errors++;
      $display("FAIL loopback got %b want %b", loopback, exp_lb); end
    @(posedge io_clk); #1;
    checks++; if (link_reset_req !== 1'b0) begin errors++;
      $display("FAIL lrr_width got %b want 0", link_reset_req); end
    e = exp_reg(20'd5, 16);
    do_read(20'd5, 0);
    checks++; if (rd !== e) begin errors++; $display("FAIL ctrl_read got %h want %h", rd, e); end
  endtask

  task automatic test_scratch;
    do_write(20'd6, 32'hA5A5_0F0F, 0);
    e = exp_reg(20'd6, 16);
    do_read(20'd6, 0);
    checks++; if (rd !== e) begin errors++; $display("FAIL scratch got %h want %h", rd, e); end
    for (int i = 0; i < 4; i++) begin
      do_write(20'd6, $urandom, 0);
      do_write(20'h16, $urandom, 0);
      do_write(20'd1, $urandom & 32'hFFFF_FFFE, 0);
      e = exp_reg(20'd6, 16);
      do_read(20'd6, 0);
      checks++; if (rd !== e) begin errors++; $display("FAIL scratch_rand got %h want %h", rd, e); end
    end
    e = exp_reg(20'd1, 16);
    do_read(20'd1, 0);
    checks++; if (rd !== e) begin errors++; $display("FAIL ro_write got %h want %h", rd, e); end
    e = exp_reg(20'd9, 16);
    do_read(20'd9, 0);
    checks++; if (rd !== e) begin errors++; $display("FAIL unmapped9 got %h want %h", rd, e); end
    e = exp_reg(20'h10, 16);
    do_read(20'h10, 0);
    checks++; if (rd !== e) begin errors++; $display("FAIL unmapped_hi got %h want %h", rd, e); end
  endtask

  task automatic test_reset_in_ack;
    @(negedge io_clk);
    io_sel = 1; io_sync = 1; io_rd_en = 1; io_addr = 20'd6;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge io_clk); #1;
      if (io_rd_ack) begin lat = i; break; end
    end
    checks++; if (lat < 0) begin errors++; $display("FAIL ack_timeout got none want ack"); end
    @(negedge io_clk); io_clk_resetN = 0;
    @(posedge io_clk); #1;
    checks++; if (io_rd_ack !== 1'b0 || io_rd_data !== 32'h0) begin errors++;
      $display("FAIL reset_in_ack got ack=%b data=%h want 0/0", io_rd_ack, io_rd_data); end
    @(negedge io_clk); io_sync = 0; io_sel = 0; io_rd_en = 0; io_clk_resetN = 1;
    exp_lb = 3'b000; exp_scratch = 32'h0;
    @(posedge io_clk); #1;
    checks++; if (loopback !== exp_lb) begin errors++; $display("FAIL lb_reset got %b want %b", loopback, exp_lb); end
    e = exp_reg(20'd6, 16);
    do_read(20'd6, 0);
    checks++; if (rd !== e) begin errors++; $display("FAIL scratch_reset got %h want %h", rd, e); end
  endtask

  task automatic test_no_ack_cases;
    acks = 0;
    @(negedge io_clk); io_sel = 0; io_sync = 1; io_rd_en = 1; io_addr = 20'd0;
    repeat (6) begin @(posedge io_clk); #1; if (io_rd_ack) acks++; end
    @(negedge io_clk); io_sync = 0; io_rd_en = 0;
    @(negedge io_clk); io_sel = 1; io_sync = 1; io_wr_en = 1; io_addr = 20'd7;
    @(negedge io_clk); io_wr_en = 0;
    repeat (6) begin @(posedge io_clk); #1; if (io_rd_ack) acks++; end
    @(negedge io_clk); io_sync = 0;
    @(negedge io_clk); io_sync = 1; io_rd_en = 1; io_addr = 20'd0;
    @(negedge io_clk); io_sync = 0; io_rd_en = 0;
    repeat (6) begin @(posedge io_clk); #1; if (io_rd_ack) acks++; end
    io_sel = 0;
    checks++; if (acks != 0) begin errors++; $display("FAIL no_ack got %0d ack cycles want 0", acks); end
  endtask

  task automatic test_back_to_back;
    acks = 0; prev_ack = 0;
    @(negedge io_clk); io_sel = 1; io_sync = 1; io_rd_en = 1; io_addr = 20'd6;
    repeat (10) begin @(posedge io_clk); #1; if (io_rd_ack && !prev_ack) acks++; prev_ack = io_rd_ack; end
    @(negedge io_clk); io_sync = 0;
    @(negedge io_clk); io_sync = 1; io_addr = 20'd0;
    e = exp_reg(20'd0, 16);
    repeat (10) begin @(posedge io_clk); #1; if (io_rd_ack && !prev_ack) acks++; prev_ack = io_rd_ack; end
    checks++; if (io_rd_data !== e) begin errors++; $display("FAIL b2b_data got %h want %h", io_rd_data, e); end
    @(negedge io_clk); io_sync = 0; io_rd_en = 0; io_sel = 0;
    repeat (3) begin @(posedge io_clk); #1; if (io_rd_ack && !prev_ack) acks++; prev_ack = io_rd_ack; end
    checks++; if (acks != 2) begin errors++; $display("FAIL b2b_acks got %0d want 2", acks); end
  endtask

  initial begin
    test_reset;
    test_status;
    test_counters;
    test_clear_edge;
    test_control;
    test_scratch;
    test_reset_in_ack;
    test_no_ack_cases;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
